// File: rtl/dmem_port_arbiter.sv
// Shares the data RAM's single port between the MEM-stage CPU access and the debug/loader requester.
// Latency: grant and RAM drive are combinational; read data and rvalid arrive one cycle after the grant.
// Backpressure: the loser sees cpu_stall=1 or dbg_gnt=0; a starved debug request is forced through, and lock lets debug hold the port.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        starve_cnt;
    logic              starve_hit;
    logic              cpu_grant;
    logic              dbg_grant;
    logic [ADDR_W-1:0] shadow_addr;
    logic [31:0]       shadow_wdata;
    logic [1:0]        rd_owner;

    assign starve_hit = (starve_cnt == 8'(STARVE_LIMIT));

    // Grant decision and next state; nothing is granted while reset is held.
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                S_CPU: begin
                    if (dbg_req && (!cpu_req || starve_hit)) begin
                        dbg_grant = 1'b1;
                    end else if (cpu_req) begin
                        cpu_grant = 1'b1;
                    end
                    if (dbg_grant && dbg_lock) begin
                        state_nxt = S_DBG;
                    end
                end
                S_DBG: begin
                    dbg_grant = dbg_req;
                    cpu_grant = cpu_req && !dbg_req;
                    if (!dbg_lock || !dbg_req) begin
                        state_nxt = S_CPU;
                    end
                end
                default: state_nxt = S_CPU;
            endcase
        end
    end

    // Ownership state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts contended cycles the debug side lost; saturates at the limit so the force stays armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (dbg_grant || !dbg_req) begin
            starve_cnt <= 8'd0;
        end else if (cpu_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Last granted address/data, held on idle cycles so the RAM inputs stay quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_addr  <= '0;
            shadow_wdata <= 32'd0;
        end else if (cpu_grant) begin
            shadow_addr  <= cpu_addr;
            shadow_wdata <= cpu_wdata;
        end else if (dbg_grant) begin
            shadow_addr  <= dbg_addr;
            shadow_wdata <= dbg_wdata;
        end
    end

    // Remembers who owns the read issued this cycle; reset drops an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= 2'b00;
        end else begin
            rd_owner <= {cpu_grant && (cpu_we == 4'd0), dbg_grant && (dbg_we == 4'd0)};
        end
    end

    // RAM port mux: the granted side drives, otherwise the shadow with writes disabled.
    always_comb begin
        ram_we    = 4'd0;
        ram_addr  = shadow_addr;
        ram_wdata = shadow_wdata;
        if (cpu_grant) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (dbg_grant) begin
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end
    end

    assign cpu_stall  = cpu_req && !cpu_grant && !rst;
    assign dbg_gnt    = dbg_grant;
    assign cpu_rvalid = rd_owner[1];
    assign dbg_rvalid = rd_owner[0];
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule
